// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues sequential word
// reads to a synchronous instruction memory, queues returned words with their
// addresses in an in-order queue and hands them to decode over valid/ready.
// A redirect reloads the PC and drops every queued and in-flight word.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   o_mem_read, o_mem_address         memory read request (address = PC)
//   i_mem_value                       read data, one cycle after the request
//   i_redirect, i_redirect_addr       PC reload and flush
//   o_valid, o_instr, o_pc, i_ready   decode handshake and payload
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RESET_ADDR  = 0,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_mem_read,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  input  logic [DATA_WIDTH-1:0] i_mem_value,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_addr,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_pc,
  input  logic                  i_ready
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] r_q_instr [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] r_q_pc    [QUEUE_DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [OCC_W-1:0]      w_occ;

  // Handshake and issue decisions; every request reserves a queue slot.
  always_comb begin
    w_pop   = o_valid & i_ready & ~i_redirect;
    w_push  = r_inflight & ~i_redirect;
    w_occ   = OCC_W'(r_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
    w_issue = ~i_rst & ~i_redirect & (w_occ < OCC_W'(QUEUE_DEPTH));
  end

  assign o_mem_read    = w_issue;
  assign o_mem_address = r_pc;
  assign o_valid       = (r_count != '0);
  assign o_instr       = r_q_instr[r_rd_ptr];
  assign o_pc          = r_q_pc[r_rd_ptr];

  // PC, in-flight tracking and queue control; reset outranks redirect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc       <= ADDR_WIDTH'(RESET_ADDR);
      r_inflight <= 1'b0;
      r_req_addr <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else if (i_redirect) begin
      // Clearing inflight makes the response arriving next cycle be ignored.
      r_pc       <= i_redirect_addr;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc       <= r_pc + ADDR_WIDTH'(1);
        r_req_addr <= r_pc;
      end
      if (w_push) begin
        r_q_instr[r_wr_ptr] <= i_mem_value;
        r_q_pc[r_wr_ptr]    <= r_req_addr;
        r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios against a synchronous memory
// model holding mem[k] = k + 0x1000.
module tb_fetch_unit;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;

  logic          i_clk;
  logic          i_rst;
  logic          o_mem_read;
  logic [AW-1:0] o_mem_address;
  logic [DW-1:0] i_mem_value;
  logic          i_redirect;
  logic [AW-1:0] i_redirect_addr;
  logic          o_valid;
  logic [DW-1:0] o_instr;
  logic [AW-1:0] o_pc;
  logic          i_ready;

  int n_cmp;
  int n_err;

  logic [AW-1:0] got_pc    [8];
  logic [DW-1:0] got_instr [8];
  int            got;

  fetch_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_ADDR(0), .QUEUE_DEPTH(2)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_mem_read(o_mem_read), .o_mem_address(o_mem_address),
    .i_mem_value(i_mem_value),
    .i_redirect(i_redirect), .i_redirect_addr(i_redirect_addr),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .i_ready(i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Synchronous memory: data appears the cycle after the request.
  always @(posedge i_clk) begin
    if (o_mem_read) i_mem_value <= 32'(o_mem_address) + 32'h1000;
  end

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1; i_redirect = 1'b0; i_ready = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
  endtask

  // Collect up to n accepted words within a bounded number of cycles.
  task automatic collect(input int n);
    got = 0;
    for (int k = 0; k < 30 && got < n; k++) begin
      @(negedge i_clk); #1;
      if (o_valid && i_ready) begin
        got_pc[got]    = o_pc;
        got_instr[got] = o_instr;
        got++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    n_cmp++; if (o_mem_read !== 1'b0) begin n_err++; $display("FAIL reset_read got=%b exp=0", o_mem_read); end
    n_cmp++; if (o_mem_address !== 14'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", o_mem_address); end
    n_cmp++; if (o_instr !== 32'h0 || o_pc !== 14'h0) begin n_err++; $display("FAIL reset_head got=%h/%h exp=0/0", o_instr, o_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      i_rst = 1'b0; i_ready = 1'b1;
      #1;
      n_cmp++;
      if (o_mem_read !== 1'b1 || o_mem_address !== AW'(c)) begin
        n_err++; $display("FAIL stream_req c=%0d got=%b/%h exp=1/%h", c, o_mem_read, o_mem_address, AW'(c));
      end
      n_cmp++;
      if (o_valid !== (c >= 2)) begin
        n_err++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, o_valid, (c >= 2));
      end else if (c >= 2) begin
        n_cmp++;
        if (o_pc !== AW'(c - 2) || o_instr !== 32'(c - 2) + 32'h1000) begin
          n_err++; $display("FAIL stream_head c=%0d got=%h/%h exp=%h/%h", c, o_pc, o_instr, AW'(c - 2), 32'(c - 2) + 32'h1000);
        end
      end
    end
  endtask

  task automatic test_stall();
    int issued;
    issued = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      i_rst = 1'b0; i_ready = 1'b0;
      #1;
      if (o_mem_read) issued++;
      n_cmp++;
      if (o_mem_read !== (c < 2)) begin
        n_err++; $display("FAIL stall_read c=%0d got=%b exp=%b", c, o_mem_read, (c < 2));
      end
      if (c >= 2) begin
        n_cmp++;
        if (o_valid !== 1'b1 || o_instr !== 32'h1000) begin
          n_err++; $display("FAIL stall_head c=%0d got=%b/%h exp=1/00001000", c, o_valid, o_instr);
        end
      end
    end
    n_cmp++; if (issued != 2) begin n_err++; $display("FAIL stall_issued got=%0d exp=2", issued); end
    i_ready = 1'b1;
    got = 0;
    // The head is visible at this sample with i_ready now high; it counts.
    #1;
    if (o_valid) begin got_pc[0] = o_pc; got_instr[0] = o_instr; end
    for (int k = 0; k < 30 && got < 2; k++) begin
      @(negedge i_clk); #1;
      if (o_valid && i_ready) begin
        got_pc[got + 1]    = o_pc;
        got_instr[got + 1] = o_instr;
        got++;
      end
    end
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (got_instr[j] !== 32'h1000 + 32'(j) || got_pc[j] !== AW'(j)) begin
        n_err++; $display("FAIL stall_drain j=%0d got=%h/%h exp=%h/%h", j, got_pc[j], got_instr[j], AW'(j), 32'h1000 + 32'(j));
      end
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    @(negedge i_clk); i_rst = 1'b0; i_ready = 1'b0;
    @(negedge i_clk);
    // One word queued and one in flight.
    @(negedge i_clk);
    i_redirect = 1'b1; i_redirect_addr = 14'h0100;
    #1;
    n_cmp++; if (o_mem_read !== 1'b0) begin n_err++; $display("FAIL flush_read_in_redirect got=%b exp=0", o_mem_read); end
    @(negedge i_clk);
    i_redirect = 1'b0; i_ready = 1'b1;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b exp=0", o_valid); end
    n_cmp++;
    if (o_mem_read !== 1'b1 || o_mem_address !== 14'h0100) begin
      n_err++; $display("FAIL flush_req got=%b/%h exp=1/0100", o_mem_read, o_mem_address);
    end
    collect(2);
    n_cmp++;
    if (got != 2 || got_pc[0] !== 14'h0100 || got_instr[0] !== 32'h1100 || got_pc[1] !== 14'h0101) begin
      n_err++; $display("FAIL flush_words got=%0d %h/%h %h exp=2 0100/00001100 0101", got, got_pc[0], got_instr[0], got_pc[1]);
    end
  endtask

  task automatic test_wrap();
    @(negedge i_clk);
    i_redirect = 1'b1; i_redirect_addr = 14'h3FFF; i_ready = 1'b1;
    @(negedge i_clk);
    i_redirect = 1'b0;
    #1;
    n_cmp++; if (o_mem_address !== 14'h3FFF) begin n_err++; $display("FAIL wrap_req0 got=%h exp=3fff", o_mem_address); end
    @(negedge i_clk); #1;
    n_cmp++; if (o_mem_address !== 14'h0000) begin n_err++; $display("FAIL wrap_req1 got=%h exp=0000", o_mem_address); end
    collect(3);
    n_cmp++;
    if (got != 3 || got_pc[0] !== 14'h3FFF || got_instr[0] !== 32'h4FFF ||
        got_pc[1] !== 14'h0000 || got_pc[2] !== 14'h0001 || got_instr[2] !== 32'h1001) begin
      n_err++; $display("FAIL wrap_seq got=%0d %h %h %h exp=3 3fff 0000 0001", got, got_pc[0], got_pc[1], got_pc[2]);
    end
  endtask

  task automatic test_redirect_pop();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge i_clk); #1;
      if (o_valid) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL rp_wait_valid got=0 exp=1"); end
    i_redirect = 1'b1; i_redirect_addr = 14'h0200; i_ready = 1'b1;
    #1;
    n_cmp++; if (o_mem_read !== 1'b0) begin n_err++; $display("FAIL rp_read got=%b exp=0", o_mem_read); end
    @(negedge i_clk);
    i_redirect = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rp_valid got=%b exp=0", o_valid); end
    collect(1);
    n_cmp++;
    if (got != 1 || got_pc[0] !== 14'h0200 || got_instr[0] !== 32'h1200) begin
      n_err++; $display("FAIL rp_next got=%0d %h/%h exp=1 0200/00001200", got, got_pc[0], got_instr[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge i_clk); #1;
      if (o_valid && o_mem_read) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL rm_wait got=0 exp=1"); end
    i_rst = 1'b1;
    @(negedge i_clk); #1;
    n_cmp++;
    if (o_valid !== 1'b0 || o_mem_read !== 1'b0) begin
      n_err++; $display("FAIL rm_cleared got=%b/%b exp=0/0", o_valid, o_mem_read);
    end
    n_cmp++;
    if (o_mem_address !== 14'h0 || o_instr !== 32'h0 || o_pc !== 14'h0) begin
      n_err++; $display("FAIL rm_state got=%h/%h/%h exp=0/0/0", o_mem_address, o_instr, o_pc);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    n_cmp++;
    if (o_mem_read !== 1'b1 || o_mem_address !== 14'h0) begin
      n_err++; $display("FAIL rm_restart got=%b/%h exp=1/0000", o_mem_read, o_mem_address);
    end
    collect(2);
    n_cmp++;
    if (got != 2 || got_pc[0] !== 14'h0 || got_instr[0] !== 32'h1000 || got_pc[1] !== 14'h1 || got_instr[1] !== 32'h1001) begin
      n_err++; $display("FAIL rm_words got=%0d %h/%h %h/%h exp=2 0000/00001000 0001/00001001",
                        got, got_pc[0], got_instr[0], got_pc[1], got_instr[1]);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    i_rst = 1'b1; i_ready = 1'b0; i_redirect = 1'b0; i_redirect_addr = '0;
    i_mem_value = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_wrap();
    test_redirect_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
